// File: rtl/icache_req_ctrl.sv
// Fetch-side request sequencer for the ICache addr_ok/data_ok interface.
// Holds one request until accepted, counts in-order responses, drops stale ones after flush.
module icache_req_ctrl #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        req_valid,
  input  logic [31:0] req_pc,
  output logic        req_ready,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_addr_ok,
  input  logic        icache_data_ok,
  input  logic [31:0] icache_rdata1,
  input  logic [31:0] icache_rdata2,
  output logic        resp_valid,
  output logic [31:0] resp_inst1,
  output logic [31:0] resp_inst2,
  output logic [2:0]  outstanding,
  output logic        busy,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2
  } state_e;

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  pending_cnt_q, pending_cnt_d;
  logic [2:0]  drop_cnt_q, drop_cnt_d;
  logic        proto_err_q, proto_err_d;

  logic accept;
  logic issue_done;
  logic rsp_any;
  logic rsp_drop;
  logic rsp_live;
  logic unused_pc_lsb;

  assign unused_pc_lsb = ^req_pc[2:0];

  assign outstanding = pending_cnt_q + drop_cnt_q;
  assign req_ready   = (state_q == IDLE) && !flush && (outstanding < MAX_CNT);
  assign accept      = req_valid && req_ready;
  assign icache_req  = (state_q != IDLE);
  assign icache_addr = addr_q;
  assign busy        = (state_q != IDLE) || (outstanding != 3'd0);
  assign proto_err   = proto_err_q;

  assign issue_done = (state_q != IDLE) && icache_addr_ok;
  // A data_ok with nothing outstanding is a protocol error and must not touch counters.
  assign rsp_any    = icache_data_ok && (outstanding != 3'd0);
  assign rsp_drop   = rsp_any && (drop_cnt_q != 3'd0);
  assign rsp_live   = rsp_any && (drop_cnt_q == 3'd0);

  assign resp_valid = rsp_live && !flush;
  assign resp_inst1 = icache_rdata1;
  assign resp_inst2 = icache_rdata2;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    pending_cnt_d = pending_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    proto_err_d   = proto_err_q | (icache_data_ok && (outstanding == 3'd0));

    if (flush) begin
      // Everything already in flight, including a request accepted this cycle, becomes stale.
      drop_cnt_d    = drop_cnt_q + pending_cnt_q + {2'b00, issue_done} - {2'b00, rsp_any};
      pending_cnt_d = 3'd0;
      state_d       = ((state_q != IDLE) && !icache_addr_ok) ? KILL : IDLE;
    end else begin
      pending_cnt_d = pending_cnt_q + {2'b00, issue_done && (state_q == REQ)}
                      - {2'b00, rsp_live};
      drop_cnt_d    = drop_cnt_q + {2'b00, issue_done && (state_q == KILL)}
                      - {2'b00, rsp_drop};
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = REQ;
            addr_d  = {req_pc[31:3], 3'b000};
          end
        end
        REQ, KILL: begin
          if (icache_addr_ok) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      addr_q        <= 32'd0;
      pending_cnt_q <= 3'd0;
      drop_cnt_q    <= 3'd0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      pending_cnt_q <= pending_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      proto_err_q   <= proto_err_d;
    end
  end

endmodule
